// File: rtl/dither_sched.sv
// Dither-sample scheduler: reseeds and warms up an external generator, then hands one
// scaled generator sample per cycle to round-robin-selected modulator channels.
module dither_sched #(
  parameter int W        = 24,
  parameter int N_CH     = 4,
  parameter int WARM_CYC = 4,
  localparam int PW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en_i,
  input  logic            reseed_i,
  input  logic [2:0]      shift_i,
  input  logic [W-1:0]    dith_i,
  input  logic [N_CH-1:0] req_i,
  output logic            gen_reset_o,
  output logic [N_CH-1:0] gnt_o,
  output logic [W-1:0]    dith_o,
  output logic            dith_vld_o,
  output logic            busy_o,
  output logic [1:0]      state_o,
  output logic [PW-1:0]   ptr_o
);

  localparam int CW = $clog2(WARM_CYC + 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RESEED = 2'd1,
    S_WARM   = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [N_CH-1:0] gnt_q, gnt_d;
  logic [W-1:0]    dith_q, dith_d;

  logic            found;
  logic [PW-1:0]   sel;
  logic [PW:0]     sum;
  logic            grant_ok;
  logic signed [W-1:0] dith_s;

  assign dith_s = dith_i;

  // Descending scan so the last hit, i.e. the one nearest ptr, wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_CH)) sum = sum - (PW+1)'(N_CH);
      if (req_i[sum[PW-1:0]]) begin
        found = 1'b1;
        sel   = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_d    = '0;
    dith_d   = dith_q;
    grant_ok = (state_q == S_RUN) && en_i && !reseed_i && found;

    if (grant_ok) begin
      gnt_d[sel] = 1'b1;
      ptr_d      = (sel == PW'(N_CH - 1)) ? '0 : sel + 1'b1;
      dith_d     = dith_s >>> shift_i;
    end

    if (reseed_i) begin
      state_d = S_RESEED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (en_i) state_d = S_RUN;
        S_RESEED: begin
          if (cnt_q == CW'(1)) begin
            state_d = S_WARM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WARM: begin
          if (cnt_q == CW'(WARM_CYC - 1)) begin
            state_d = en_i ? S_RUN : S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: if (!en_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RESEED;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      dith_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      dith_q  <= dith_d;
    end
  end

  assign gen_reset_o = (state_q == S_RESEED);
  assign busy_o      = (state_q == S_RESEED) || (state_q == S_WARM);
  assign gnt_o       = gnt_q;
  assign dith_vld_o  = |gnt_q;
  assign dith_o      = dith_q;
  assign state_o     = state_q;
  assign ptr_o       = ptr_q;

endmodule

// File: tb/tb_dither_sched.sv
// Bench for dither_sched: a reference model pushes expected outputs per cycle,
// scenario tasks pop and compare them and add fixed-value sequence checks.
module tb_dither_sched;

  localparam int W        = 24;
  localparam int N_CH     = 4;
  localparam int WARM_CYC = 4;
  localparam int PW       = 2;
  localparam int EW       = 2 + PW + 3 + N_CH + W;

  logic            clock;
  logic            reset;
  logic            en_i;
  logic            reseed_i;
  logic [2:0]      shift_i;
  logic [W-1:0]    dith_i;
  logic [N_CH-1:0] req_i;
  logic            gen_reset_o;
  logic [N_CH-1:0] gnt_o;
  logic [W-1:0]    dith_o;
  logic            dith_vld_o;
  logic            busy_o;
  logic [1:0]      state_o;
  logic [PW-1:0]   ptr_o;

  dither_sched #(.W(W), .N_CH(N_CH), .WARM_CYC(WARM_CYC)) dut (
    .clock       (clock),
    .reset       (reset),
    .en_i        (en_i),
    .reseed_i    (reseed_i),
    .shift_i     (shift_i),
    .dith_i      (dith_i),
    .req_i       (req_i),
    .gen_reset_o (gen_reset_o),
    .gnt_o       (gnt_o),
    .dith_o      (dith_o),
    .dith_vld_o  (dith_vld_o),
    .busy_o      (busy_o),
    .state_o     (state_o),
    .ptr_o       (ptr_o)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  logic [EW-1:0] obs;
  int n_vec = 0;
  int n_err = 0;

  assign obs = {state_o, ptr_o, gen_reset_o, busy_o, dith_vld_o, gnt_o, dith_o};

  // Reference model state (0 IDLE, 1 RESEED, 2 WARM, 3 RUN)
  int              m_state = 1;
  int              m_cnt   = 0;
  int              m_ptr   = 0;
  logic [N_CH-1:0] m_gnt   = '0;
  logic [W-1:0]    m_dith  = '0;

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic e_in, input logic rs,
                       input logic [2:0] sh, input logic [W-1:0] d,
                       input logic [N_CH-1:0] q);
    int idx;
    int nptr;
    logic signed [W-1:0] ds;
    reset = r; en_i = e_in; reseed_i = rs; shift_i = sh; dith_i = d; req_i = q;
    nptr = m_ptr;
    if (r) begin
      m_state = 1; m_cnt = 0; m_ptr = 0; m_gnt = '0; m_dith = '0;
    end else begin
      m_gnt = '0;
      if (m_state == 3 && e_in && !rs) begin
        for (int i = 0; i < N_CH; i++) begin
          idx = (m_ptr + i) % N_CH;
          if (q[idx] && m_gnt == '0) begin
            m_gnt[idx] = 1'b1;
            nptr = (idx + 1) % N_CH;
          end
        end
      end
      if (m_gnt != '0) begin
        m_ptr  = nptr;
        ds     = d;
        m_dith = ds >>> sh;
      end
      if (rs) begin
        m_state = 1; m_cnt = 0;
      end else begin
        case (m_state)
          0: if (e_in) m_state = 3;
          1: if (m_cnt == 1) begin m_state = 2; m_cnt = 0; end else m_cnt++;
          2: if (m_cnt == WARM_CYC - 1) begin m_state = e_in ? 3 : 0; m_cnt = 0; end
             else m_cnt++;
          default: if (!e_in) m_state = 0;
        endcase
      end
    end
    exp_q.push_back({2'(m_state), PW'(m_ptr), (m_state == 1), (m_state == 1 || m_state == 2),
                     (m_gnt != '0), m_gnt, m_dith});
    @(posedge clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 3'($urandom), W'($urandom), N_CH'($urandom));
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL reset_model: got %h want %h", obs, e); end
      n_vec++;
      if ({gen_reset_o, busy_o, dith_vld_o, gnt_o, dith_o, ptr_o} !== {2'b11, 1'b0, 4'b0, 24'h0, 2'b0}) begin
        n_err++;
        $display("FAIL reset_values: gr=%b busy=%b vld=%b gnt=%b dith=%h ptr=%0d want 1 1 0 0000 000000 0",
                 gen_reset_o, busy_o, dith_vld_o, gnt_o, dith_o, ptr_o);
      end
    end
  endtask

  task automatic test_warm_sequence();
    int gr_cnt;
    int busy_cnt;
    int first_k;
    int ng;
    logic [N_CH-1:0] g[5];
    logic [N_CH-1:0] want[5];
    want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b1000; want[4] = 4'b0001;
    gr_cnt = int'(gen_reset_o); busy_cnt = int'(busy_o); first_k = -1; ng = 0;
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 1'b1, 1'b0, 3'($urandom), W'($urandom), 4'b1111);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL warm_model: cyc %0d got %h want %h", k, obs, e); end
      gr_cnt += int'(gen_reset_o);
      busy_cnt += int'(busy_o);
      if (gnt_o != '0) begin
        if (first_k < 0) first_k = k;
        if (ng < 5) g[ng] = gnt_o;
        ng++;
      end
    end
    n_vec++;
    if (gr_cnt != 2) begin n_err++; $display("FAIL warm_gen_reset_len: got %0d want 2", gr_cnt); end
    n_vec++;
    if (busy_cnt != 2 + WARM_CYC) begin n_err++; $display("FAIL warm_busy_len: got %0d want %0d", busy_cnt, 2 + WARM_CYC); end
    n_vec++;
    if (first_k != 6) begin n_err++; $display("FAIL warm_first_grant: got cyc %0d want 6", first_k); end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (i >= ng || g[i] !== want[i]) begin
        n_err++; $display("FAIL warm_rr_seq[%0d]: got %b want %b", i, (i < ng) ? g[i] : 4'bx, want[i]);
      end
    end
  endtask

  task automatic test_rr_mask();
    logic [N_CH-1:0] prev;
    prev = '0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 1'b0, 3'($urandom), W'($urandom), 4'b0101);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL rr_mask_model: cyc %0d got %h want %h", k, obs, e); end
      n_vec++;
      if (!(gnt_o == 4'b0001 || gnt_o == 4'b0100) || gnt_o == prev) begin
        n_err++; $display("FAIL rr_mask_alt: cyc %0d got %b prev %b want alternating 0001/0100", k, gnt_o, prev);
      end
      prev = gnt_o;
    end
  endtask

  task automatic test_shift();
    logic [W-1:0] din[3];
    logic [2:0]   sh[3];
    logic [W-1:0] want[3];
    din[0] = 24'h800000; sh[0] = 3'd3; want[0] = 24'hF00000;
    din[1] = 24'h000010; sh[1] = 3'd4; want[1] = 24'h000001;
    din[2] = 24'hFFFFFF; sh[2] = 3'd7; want[2] = 24'hFFFFFF;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, sh[k], din[k], 4'b0001);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL shift_model: vec %0d got %h want %h", k, obs, e); end
      n_vec++;
      if (dith_o !== want[k] || dith_vld_o !== 1'b1) begin
        n_err++; $display("FAIL shift_fixed: vec %0d got %h vld %b want %h vld 1", k, dith_o, dith_vld_o, want[k]);
      end
    end
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, 1'b0, 3'($urandom), W'($urandom), N_CH'($urandom_range(1, 15)));
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL shift_rand: vec %0d got %h want %h", k, obs, e); end
    end
  endtask

  task automatic test_reseed_run();
    int gr_cnt;
    int first_k;
    drive(1'b0, 1'b1, 1'b1, 3'($urandom), W'($urandom), 4'b0010);
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL reseed_model: pulse got %h want %h", obs, e); end
    n_vec++;
    if (gnt_o !== 4'b0000) begin n_err++; $display("FAIL reseed_no_grant: got %b want 0000", gnt_o); end
    gr_cnt = int'(gen_reset_o); first_k = -1;
    for (int k = 1; k < 10; k++) begin
      drive(1'b0, 1'b1, 1'b0, 3'($urandom), W'($urandom), 4'b0010);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL reseed_model: cyc %0d got %h want %h", k, obs, e); end
      gr_cnt += int'(gen_reset_o);
      if (gnt_o != '0 && first_k < 0) begin
        first_k = k;
        n_vec++;
        if (gnt_o !== 4'b0010) begin n_err++; $display("FAIL reseed_grant_val: got %b want 0010", gnt_o); end
      end
    end
    n_vec++;
    if (gr_cnt != 2) begin n_err++; $display("FAIL reseed_gen_reset_len: got %0d want 2", gr_cnt); end
    n_vec++;
    if (first_k != 7) begin n_err++; $display("FAIL reseed_first_grant: got cyc %0d want 7", first_k); end
  endtask

  task automatic test_en_drop();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, (k < 3 || k > 5), 1'b0, 3'($urandom), W'($urandom), 4'b1111);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL en_drop_model: cyc %0d got %h want %h", k, obs, e); end
      if (k >= 3 && k <= 6) begin
        n_vec++;
        if (gnt_o !== 4'b0000) begin n_err++; $display("FAIL en_drop_nogrant: cyc %0d got %b want 0000", k, gnt_o); end
      end
    end
  endtask

  task automatic test_reseed_restart();
    int gr_cnt;
    gr_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, (k < 2), 3'($urandom), W'($urandom), 4'b1111);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL restart_model: cyc %0d got %h want %h", k, obs, e); end
      gr_cnt += int'(gen_reset_o);
    end
    n_vec++;
    if (gr_cnt != 3) begin n_err++; $display("FAIL restart_gen_reset_len: got %0d want 3", gr_cnt); end
  endtask

  task automatic test_reset_mid_run();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 1'b0, 3'($urandom), W'($urandom), 4'b1111);
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL midrst_model: cyc %0d got %h want %h", k, obs, e); end
    end
    drive(1'b1, 1'b1, 1'b0, 3'($urandom), W'($urandom), 4'b1111);
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL midrst_model: reset got %h want %h", obs, e); end
    n_vec++;
    if (gnt_o !== 4'b0000 || dith_o !== 24'h0) begin
      n_err++; $display("FAIL midrst_clear: gnt %b dith %h want 0000 000000", gnt_o, dith_o);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
            3'($urandom), W'($urandom), N_CH'($urandom));
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL random: cyc %0d got %h want %h", k, obs, e); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1; en_i = 1'b0; reseed_i = 1'b0; shift_i = '0; dith_i = '0; req_i = '0;
    test_reset();
    test_warm_sequence();
    test_rr_mask();
    test_shift();
    test_reseed_run();
    test_en_drop();
    test_reseed_restart();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
